// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered 16-bit ALU among NREQ requesters
// Optional build macro: ALU_ARB_STATS_EN (adds op_count / ovf_count statistics outputs)
module alu_arbiter #(
  parameter int BW   = 16,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BW-1:0]   req_a,
  input  logic [NREQ*BW-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [BW-1:0]        rsp_data,
  output logic [2:0]           rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]          op_count,
  output logic [15:0]          ovf_count
`endif
);

  // FSM encoding: a grant in IDLE, one compute cycle, then hold the response
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_INC   = 4'b0101;
  localparam logic [3:0] OP_PASSA = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;

  // Largest positive two's-complement value; INC overflows only from here
  localparam logic [BW-1:0] MAX_POS = {1'b0, {(BW-1){1'b1}}};

  logic [1:0]     r_state;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] r_id;
  logic [BW-1:0]  r_a;
  logic [BW-1:0]  r_b;
  logic [3:0]     r_op;

  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [BW-1:0]  r_rsp_data;
  logic [2:0]     r_rsp_flags;

  logic           w_grant_found;
  logic [IDW-1:0] w_grant_idx;
  logic [BW-1:0]  w_sel_a;
  logic [BW-1:0]  w_sel_b;
  logic [3:0]     w_sel_op;
  logic [BW-1:0]  w_result;
  logic           w_ovf;
  logic [2:0]     w_flags;
  logic           w_rsp_fire;

  // Round-robin search: first valid requester after the last winner, wrapping modulo NREQ
  always_comb begin
    logic [IDW-1:0] w_cand;
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    w_cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_last) + k) % NREQ);
      if (!w_grant_found && req_valid[w_cand]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // Grant is combinational so the requester sees its handshake in the same IDLE cycle
  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && w_grant_found) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Operand/opcode mux for the winning requester
  always_comb begin
    w_sel_a  = req_a[w_grant_idx*BW +: BW];
    w_sel_b  = req_b[w_grant_idx*BW +: BW];
    w_sel_op = req_op[w_grant_idx*4 +: 4];
  end

  // ALU on the latched operands; overflow uses the sign-bit rules of each operation
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_result = r_a + r_b;
        w_ovf    = (r_a[BW-1] == r_b[BW-1]) && (w_result[BW-1] != r_a[BW-1]);
      end
      OP_SUB: begin
        w_result = r_a - r_b;
        w_ovf    = (r_a[BW-1] != r_b[BW-1]) && (w_result[BW-1] != r_a[BW-1]);
      end
      OP_AND:   w_result = r_a & r_b;
      OP_OR:    w_result = r_a | r_b;
      OP_XOR:   w_result = r_a ^ r_b;
      OP_INC: begin
        w_result = r_a + BW'(1);
        w_ovf    = (r_a == MAX_POS);
      end
      OP_PASSA: w_result = r_a;
      OP_PASSB: w_result = r_b;
      default:  w_result = '0;
    endcase
    w_flags = {w_ovf, w_result[BW-1], (w_result == '0)};
  end

  assign w_rsp_fire = r_rsp_valid && rsp_ready;

  // Control FSM with operand latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_found) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_id    <= w_grant_idx;
            r_last  <= w_grant_idx;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_data  <= w_result;
          r_rsp_flags <= w_flags;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_flags = r_rsp_flags;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_op_count;
  logic [15:0] r_ovf_count;

  // Saturating counters of completed responses and of those reporting overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count  <= '0;
      r_ovf_count <= '0;
    end else if (w_rsp_fire) begin
      if (r_op_count != 32'hFFFF_FFFF) begin
        r_op_count <= r_op_count + 32'd1;
      end
      if (r_rsp_flags[2] && (r_ovf_count != 16'hFFFF)) begin
        r_ovf_count <= r_ovf_count + 16'd1;
      end
    end
  end

  assign op_count  = r_op_count;
  assign ovf_count = r_ovf_count;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against a behavioural model
module tb_alu_arbiter;

  localparam int BW   = 16;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*BW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ*4-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [BW-1:0]     rsp_data;
  logic [2:0]        rsp_flags;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]       op_count;
  logic [15:0]       ovf_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: pointer, in-flight transaction and its expected response
  int          m_last;
  bit          m_busy;
  int          m_cnt;
  logic [1:0]  e_id;
  logic [15:0] e_data;
  logic [2:0]  e_flags;
  int          q_grants[$];

  alu_arbiter #(.BW(BW), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags)
`ifdef ALU_ARB_STATS_EN
    ,
    .op_count  (op_count),
    .ovf_count (ovf_count)
`endif
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result and flags from signed integer arithmetic: {overflow, negative, zero, data}
  function automatic logic [18:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa;
    int sb;
    int s;
    logic [15:0] r;
    bit ovf;
    sa = $signed(a);
    sb = $signed(b);
    s = 0;
    ovf = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
      4'd1: begin s = sa - sb; r = 16'(s); ovf = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin s = sa + 1; r = 16'(s); ovf = (s > 32767); end
      4'd6: r = a;
      4'd7: r = b;
      default: r = 16'h0000;
    endcase
    return {ovf, r[15], (r == 16'h0000), r};
  endfunction

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset_pulse();
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_busy = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b0;
    #2;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags} !== '0) begin
      n_err++;
      $display("FAIL reset_values got ready=%b valid=%b id=%0d data=%h flags=%b exp all zero",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_last = NREQ - 1;
    m_busy = 1'b0;
    m_cnt = 0;
  endtask

  // One isolated request: grant in T, silent T+1, response in T+2, idle in T+3
  task automatic run_single(input int idx, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] op, input logic [15:0] ed, input logic [2:0] ef,
                            input string nm);
    logic [3:0] onehot;
    onehot = 4'(1 << idx);
    @(posedge clk); #1;
    req_valid = onehot;
    req_a[idx*BW +: BW] = a;
    req_b[idx*BW +: BW] = b;
    req_op[idx*4 +: 4] = op;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== onehot) begin
      n_err++;
      $display("FAIL %s grant got=%b exp=%b", nm, req_ready, onehot);
    end
    m_last = idx;
    @(posedge clk); #1;
    req_valid = '0;
    req_a[idx*BW +: BW] = 16'($urandom);
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s early_rsp got valid=%b exp 0 in T+1", nm, rsp_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_flags} !== {1'b1, 2'(idx), ed, ef}) begin
      n_err++;
      $display("FAIL %s response got valid=%b id=%0d data=%h flags=%b exp valid=1 id=%0d data=%h flags=%b",
               nm, rsp_valid, rsp_id, rsp_data, rsp_flags, idx, ed, ef);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, req_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL %s post_handshake got valid=%b ready=%b exp 0", nm, rsp_valid, req_ready);
    end
  endtask

  // Cycle-by-cycle scoreboard; mode 0 random, 1 all valid, 2 all valid with 10-cycle backpressure
  task automatic run_engine(input int ncyc, input int mode, input string nm);
    int c;
    int bp;
    int grant;
    int i;
    logic [3:0] exp_ready;
    logic exp_rv;
    logic [18:0] r;
    c = 0;
    bp = 0;
    while (c < ncyc || m_busy) begin
      if (c >= ncyc + 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s drain_timeout got busy after %0d cycles exp idle", nm, c);
        m_busy = 1'b0;
        break;
      end
      @(posedge clk); #1;
      if (c >= ncyc) begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end else begin
        for (int j = 0; j < NREQ; j++) begin
          req_a[j*BW +: BW] = rand_word();
          req_b[j*BW +: BW] = rand_word();
          req_op[j*4 +: 4] = 4'($urandom_range(0, 15));
        end
        case (mode)
          0: begin req_valid = 4'($urandom); rsp_ready = ($urandom_range(0, 3) != 0); end
          1: begin req_valid = '1; rsp_ready = 1'b1; end
          default: begin req_valid = '1; rsp_ready = (bp >= 10); end
        endcase
      end
      @(negedge clk);
      grant = -1;
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          i = (m_last + k) % NREQ;
          if (grant < 0 && req_valid[2'(i)]) grant = i;
        end
      end
      exp_ready = (grant >= 0) ? 4'(1 << grant) : 4'b0;
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL %s req_ready cyc=%0d got=%b exp=%b", nm, c, req_ready, exp_ready);
      end
      exp_rv = m_busy && (m_cnt >= 1);
      n_cmp++;
      if (rsp_valid !== exp_rv) begin
        n_err++;
        $display("FAIL %s rsp_valid cyc=%0d got=%b exp=%b", nm, c, rsp_valid, exp_rv);
      end
      if (exp_rv) begin
        n_cmp++;
        if ({rsp_id, rsp_data, rsp_flags} !== {e_id, e_data, e_flags}) begin
          n_err++;
          $display("FAIL %s rsp_fields cyc=%0d got id=%0d data=%h flags=%b exp id=%0d data=%h flags=%b",
                   nm, c, rsp_id, rsp_data, rsp_flags, e_id, e_data, e_flags);
        end
        if (rsp_ready) begin
          m_busy = 1'b0;
          bp = 0;
        end else begin
          bp++;
        end
      end
      if (m_busy) m_cnt++;
      if (grant >= 0) begin
        r = ref_alu(req_op[grant*4 +: 4], req_a[grant*BW +: BW], req_b[grant*BW +: BW]);
        e_flags = r[18:16];
        e_data = r[15:0];
        e_id = 2'(grant);
        m_busy = 1'b1;
        m_cnt = 0;
        m_last = grant;
        q_grants.push_back(grant);
      end
      c++;
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    run_single(0, 16'h0003, 16'h0004, 4'b0000, 16'h0007, 3'b000, "single_add");
  endtask

  task automatic test_overflow();
    run_single(1, 16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 3'b110, "add_ovf");
    run_single(2, 16'h8000, 16'h0001, 4'b0001, 16'h7FFF, 3'b100, "sub_ovf");
    run_single(3, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 3'b001, "add_wrap");
    run_single(0, 16'h7FFF, 16'h1234, 4'b0101, 16'h8000, 3'b110, "inc_ovf");
  endtask

  task automatic test_undef_pass();
    run_single(1, 16'h1234, 16'h5678, 4'b1010, 16'h0000, 3'b001, "undef_op");
    run_single(2, 16'h1234, 16'h8001, 4'b0111, 16'h8001, 3'b010, "pass_b");
  endtask

  task automatic test_random();
    run_engine(400, 0, "random");
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset_pulse();
    q_grants.delete();
    run_engine(25, 1, "round_robin");
    n_cmp++;
    if (q_grants.size() < 5) begin
      n_err++;
      $display("FAIL rr_count got=%0d grants exp>=5", q_grants.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (q_grants[k] != exp_order[k]) begin
          n_err++;
          $display("FAIL rr_order idx=%0d got=%0d exp=%0d", k, q_grants[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_engine(70, 2, "backpressure");
  endtask

  task automatic test_reset_exec();
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_op[8 +: 4] = 4'b0000;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL rst_exec_grant got=%b exp=0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags} !== '0) begin
      n_err++;
      $display("FAIL rst_exec_async got ready=%b valid=%b id=%0d data=%h flags=%b exp all zero",
               req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_exec_dropped cyc=%0d got valid=%b exp 0", k, rsp_valid);
      end
    end
`ifdef ALU_ARB_STATS_EN
    n_cmp++;
    if (op_count !== 32'd0) begin
      n_err++;
      $display("FAIL rst_exec_op_count got=%0d exp=0", op_count);
    end
`endif
    @(posedge clk); #1;
    req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_exec_first_grant got=%b exp=0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    m_last = 0;
    m_busy = 1'b0;
  endtask

  // Test sequence and summary
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_undef_pass();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
